// File: rtl/seq_compare.sv
// Multi-cycle equality / signed-unsigned magnitude comparator.
// Resolves one CHUNK-bit slice per cycle from the MSB slice down, with early exit.
module seq_compare #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         is_signed,
  output logic         busy,
  output logic         result_ready,
  output logic         isNotEqual,
  output logic         isLessThan,
  output logic [1:0]   dbg_state
);

  localparam int NCHUNK = W / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is a request taken only while busy=0 (IDLE). It is not
  // queued. result_ready pulses for exactly one cycle and isNotEqual and
  // isLessThan are valid from that cycle until the next result_ready.
  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, b_q;
  logic            signed_q;
  logic            ne_q, ne_d;
  logic            lt_q, lt_d;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic            accept;

  assign accept = (state_q == S_IDLE) && start;

  // Slice select; the MSB slice gets its sign bit flipped in signed mode so an
  // unsigned slice compare yields the two's-complement ordering.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (signed_q && (idx_q == IW'(NCHUNK - 1))) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ne_d    = ne_q;
    lt_d    = lt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = IW'(NCHUNK - 1);
        end
      end
      S_RUN: begin
        if (chunk_a != chunk_b) begin
          ne_d    = 1'b1;
          lt_d    = (chunk_a < chunk_b);
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          ne_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
    end else if (accept) begin
      a_q      <= in1;
      b_q      <= in2;
      signed_q <= is_signed;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_ready = (state_q == S_DONE);
  assign isNotEqual   = ne_q;
  assign isLessThan   = lt_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/seq_compare.md
# seq_compare

Parametrised multi-cycle magnitude/equality comparator for the processor datapath. It generalises the fixed 32-bit combinational not-equal check to any width, adds signed and unsigned less-than, and resolves the comparison one chunk per cycle from the MSB chunk down, with early exit. It uses the start/busy/result-ready handshake style of the multdiv unit, so the branch unit can issue one compare and stall until the result arrives.

## Interface
- `W`, default 32: operand width; must be a multiple of `CHUNK`.
- `CHUNK`, default 8: bits compared per cycle; `NCHUNK = W/CHUNK >= 1`. With `CHUNK = W`, every compare takes one RUN cycle.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; forces the reset state immediately.
- `start` input 1: request a compare; sampled only in IDLE.
- `in1` input W: operand A; captured on an accepted `start`.
- `in2` input W: operand B; captured on an accepted `start`.
- `is_signed` input 1: 1 selects two's-complement less-than, 0 selects unsigned; captured with the operands.
- `busy` output 1: high whenever state is not IDLE.
- `result_ready` output 1: one-cycle pulse, high only in DONE.
- `isNotEqual` output 1: 1 when A differs from B.
- `isLessThan` output 1: 1 when A < B under the captured signedness.

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE with `start=1` at an edge:
  - Latch `in1`, `in2` and `is_signed`.
  - Set chunk index `idx = NCHUNK-1` (the MSB chunk).
  - Go to RUN.
- IDLE with `start=0`: stay in IDLE.
- `start` is ignored in RUN and DONE. It is neither queued nor allowed to disturb the latched operands.
- Each RUN cycle compares chunk `idx` of A and B.
  - For the MSB chunk with signed mode set, the chunk's top bit is inverted on both operands before the unsigned chunk compare.
- Chunk differs:
  - Register `isNotEqual=1`.
  - Register `isLessThan = (chunkA < chunkB)`.
  - Go to DONE. This is the early exit.
- Chunk equal and `idx == 0`:
  - Register `isNotEqual=0` and `isLessThan=0`.
  - Go to DONE.
- Chunk equal and `idx > 0`: decrement `idx` and stay in RUN.
- DONE lasts exactly one cycle with `result_ready=1`, then the block returns to IDLE.
- `isNotEqual` and `isLessThan` are updated only on the edge entering DONE. They hold their value through IDLE until the next compare finishes.
- Reset state, asynchronous:
  - State is IDLE and `idx` is 0.
  - Operand registers are 0.
  - `busy`, `result_ready`, `isNotEqual` and `isLessThan` are all 0.
- Reset during RUN or DONE aborts the compare. No `result_ready` is produced for it, and the outputs go to 0.

## Timing
- Start accepted at edge 0. RUN occupies cycles 1 through k+1, where k is the number of equal leading chunks (0 ≤ k ≤ NCHUNK-1).
- For fully equal operands, k = NCHUNK-1 and RUN covers cycles 1..NCHUNK.
- DONE occupies cycle k+2, where `result_ready` is high. The block is back in IDLE at cycle k+3.
- Latency from the start edge to `result_ready`:
  - Minimum is 2 cycles, when the MSB chunk differs.
  - Maximum is NCHUNK+1 cycles, when the difference is in the LSB chunk or the operands are equal.
- Throughput: a new `start` is accepted at the earliest one cycle after DONE, in IDLE. Back-to-back `start` held high is accepted on the first IDLE edge.
- All outputs are registered, with no combinational path from the inputs.
- Release of `reset` is synchronised by the integrator. The block needs no extra cycles after release.

## Test plan
All scenarios use W=32, CHUNK=8 (NCHUNK=4).
- Reset asserted mid-idle, then released → `busy=0`, `result_ready=0`, `isNotEqual=0`, `isLessThan=0` with no clock edge needed.
- `in1=in2=0xDEADBEEF`, unsigned, start pulse → `result_ready` 5 cycles after the start edge; `isNotEqual=0`, `isLessThan=0`; `busy` high for 5 cycles.
- `in1=0x80000000`, `in2=0x00000001`:
  - Unsigned → `result_ready` after 2 cycles, `isNotEqual=1`, `isLessThan=0`.
  - Same operands signed → `isNotEqual=1`, `isLessThan=1`, also after 2 cycles.
- `in1=0x12345600`, `in2=0x12345601`, signed → `result_ready` after 5 cycles, `isNotEqual=1`, `isLessThan=1`.
- Operands held at `0x12345600`/`0x12345601` with `start` kept high for 10 cycles → one result every 6 cycles (5 latency plus the IDLE acceptance cycle).
- Compare `0xFFFFFFFF` vs `0x0` unsigned, then re-assert `start` with `in1=in2=0` during RUN:
  - The second start is ignored.
  - The single result is `isNotEqual=1`, `isLessThan=0` at cycle 2.
  - The outputs hold until the next accepted compare.
- Assert `reset` in RUN cycle 2 of an equal-operand compare → `busy` falls immediately and no `result_ready` pulse appears. A following compare of `5` vs `7` unsigned then completes normally with `isNotEqual=1`, `isLessThan=1` at 5 cycles.
